// File: rtl/stream_demux.sv
// Registered 1-to-N packet demultiplexer with a one-entry holding slot per output.
// Destination is captured on the first beat of a packet and held until the last beat.
//
//   state | meaning
//   IDLE  | between packets; next accepted beat is a first beat, routed by in_sel
//   PKT   | packet open, beats routed to locked dest
//   DROP  | packet open with invalid select, beats consumed and discarded
module stream_demux #(
   parameter int WIDTH = 8,
   parameter int N_OUT = 2,
   localparam int SEL_W = $clog2(N_OUT)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [WIDTH-1:0]       in_data,
   input  logic [SEL_W-1:0]       in_sel,
   input  logic                   in_last,
   output logic [N_OUT-1:0]       out_valid,
   input  logic [N_OUT-1:0]       out_ready,
   output logic [N_OUT*WIDTH-1:0] out_data,
   output logic [N_OUT-1:0]       out_last,
   output logic                   busy,
   output logic                   err_sel
);

   typedef enum logic [1:0] {IDLE, PKT, DROP} state_t;

   state_t           state, state_nxt;
   logic [SEL_W-1:0] dest;
   logic [SEL_W-1:0] tgt;
   logic             sel_ok;
   logic             tgt_ok;
   logic             tgt_free;
   logic             accept;
   logic [N_OUT-1:0] load;

   always_comb begin
      // one extra bit keeps the range check meaningful when N_OUT is a power of two
      sel_ok   = ({1'b0, in_sel} < (SEL_W+1)'(N_OUT));
      tgt      = (state == IDLE) ? in_sel : dest;
      tgt_ok   = (state == PKT) || ((state == IDLE) && sel_ok);
      tgt_free = 1'b0;
      for (int k = 0; k < N_OUT; k++) begin
         if (tgt == SEL_W'(k))
            tgt_free = !out_valid[k] || out_ready[k];
      end
      in_ready = tgt_ok ? tgt_free : 1'b1;
      accept   = in_valid && in_ready;
      load     = '0;
      for (int k = 0; k < N_OUT; k++) begin
         load[k] = accept && tgt_ok && (tgt == SEL_W'(k));
      end

      state_nxt = state;
      case (state)
         IDLE:     if (accept && !in_last) state_nxt = sel_ok ? PKT : DROP;
         PKT,
         DROP:     if (accept && in_last)  state_nxt = IDLE;
         default:  state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         dest    <= '0;
         err_sel <= 1'b0;
      end else begin
         state   <= state_nxt;
         err_sel <= accept && (state == IDLE) && !sel_ok;
         if (accept && (state == IDLE) && sel_ok && !in_last)
            dest <= in_sel;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= '0;
         out_data  <= '0;
         out_last  <= '0;
      end else begin
         for (int k = 0; k < N_OUT; k++) begin
            if (load[k]) begin
               out_valid[k]                <= 1'b1;
               out_data[k*WIDTH +: WIDTH]  <= in_data;
               out_last[k]                 <= in_last;
            end else if (out_ready[k]) begin
               out_valid[k] <= 1'b0;
            end
         end
      end
   end

   assign busy = (state != IDLE);

endmodule
